multi_lane_sdp_ram: RTL and testbench

//  Simple dual-port block RAM, NUM_LANES independent LANE_WIDTH-bit lanes per word, per-lane write enables.

---
 rtl/multi_lane_sdp_ram_if.sv | 27 ++
 rtl/multi_lane_sdp_ram.sv | 137 +++++++++++++
 tb/tb_multi_lane_sdp_ram.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_lane_sdp_ram_if.sv
// rtl/multi_lane_sdp_ram_if.sv - write/read bus bundle for the multi-lane simple dual-port RAM
interface multi_lane_sdp_ram_if #(
    parameter int LANE_WIDTH = 10,
    parameter int NUM_LANES  = 2,
    parameter int ADDR_WIDTH = 14
);
    localparam int W = LANE_WIDTH * NUM_LANES;

    logic [W-1:0]          wdata;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [NUM_LANES-1:0]  we;
    logic [ADDR_WIDTH-1:0] raddr;
    logic                  re;
    logic [W-1:0]          rdata;
    logic                  rvalid;
    logic                  busy;

    modport master (
        output wdata, waddr, we, raddr, re,
        input  rdata, rvalid, busy
    );

    modport slave (
        input  wdata, waddr, we, raddr, re,
        output rdata, rvalid, busy
    );
endinterface

// File: rtl/multi_lane_sdp_ram.sv
// rtl/multi_lane_sdp_ram.sv - multi-lane simple dual-port block RAM with rvalid pipeline and post-reset clear
module multi_lane_sdp_ram #(
    parameter int    LANE_WIDTH     = 10,
    parameter int    NUM_LANES      = 2,
    parameter int    ADDR_WIDTH     = 14,
    parameter string OUTPUT_REG     = "FALSE",
    parameter string RDW_MODE       = "READ_FIRST",
    parameter string CLEAR_ON_RESET = "FALSE",
    parameter string RAM_INIT_FILE  = ""
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    multi_lane_sdp_ram_if.slave  bus
);
    localparam int W      = LANE_WIDTH * NUM_LANES;
    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam bit OREG   = (OUTPUT_REG == "TRUE");
    localparam bit WFIRST = (RDW_MODE == "WRITE_FIRST");
    localparam bit CLR_EN = (CLEAR_ON_RESET == "TRUE");

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH:0]   clr_addr_q;
    logic [ADDR_WIDTH:0]   clr_addr_d;
    logic                  busy_q;

    logic [NUM_LANES-1:0]  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [W-1:0]          wr_data;
    logic                  rd_en;

    logic [W-1:0]          mem_q [DEPTH];
    logic [W-1:0]          ram_rd_q;
    logic [NUM_LANES-1:0]  byp_mask_q;
    logic [W-1:0]          byp_data_q;
    logic                  v1_q;
    logic [W-1:0]          s1;
    logic [W-1:0]          s2_q;
    logic                  v2_q;

    // The extra counter bit carries out on the last address and ends the sweep.
    assign clr_addr_d = clr_addr_q + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= CLR_EN ? ST_CLEAR : ST_IDLE;
            clr_addr_q <= '0;
            busy_q     <= CLR_EN;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    clr_addr_q <= clr_addr_d;
                    if (clr_addr_d[ADDR_WIDTH]) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // The clear sweep borrows the single write port; user traffic is dropped meanwhile.
    always_comb begin
        wr_en   = '0;
        wr_addr = bus.waddr;
        wr_data = bus.wdata;
        if (!rst_i) begin
            if (busy_q) begin
                wr_en   = '1;
                wr_addr = clr_addr_q[ADDR_WIDTH-1:0];
                wr_data = '0;
            end else begin
                wr_en   = bus.we;
            end
        end
    end

    assign rd_en = bus.re && !busy_q && !rst_i;

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NUM_LANES; k++) begin
            if (wr_en[k]) begin
                mem_q[wr_addr][k*LANE_WIDTH +: LANE_WIDTH] <= wr_data[k*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ram_rd_q <= '0;
        end else if (rd_en) begin
            ram_rd_q <= mem_q[bus.raddr];
        end
    end

    // Collided lanes are captured beside the array and merged after it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            byp_mask_q <= '0;
            byp_data_q <= '0;
            v1_q       <= 1'b0;
        end else begin
            v1_q <= rd_en;
            if (rd_en) begin
                byp_mask_q <= (WFIRST && (bus.raddr == bus.waddr)) ? wr_en : '0;
                byp_data_q <= bus.wdata;
            end
        end
    end

    always_comb begin
        s1 = ram_rd_q;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (byp_mask_q[k]) begin
                s1[k*LANE_WIDTH +: LANE_WIDTH] = byp_data_q[k*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2_q <= '0;
            v2_q <= 1'b0;
        end else begin
            s2_q <= s1;
            v2_q <= v1_q;
        end
    end

    assign bus.rdata  = OREG ? s2_q : s1;
    assign bus.rvalid = OREG ? v2_q : v1_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_multi_lane_sdp_ram.sv
// tb/tb_multi_lane_sdp_ram.sv - bench for multi_lane_sdp_ram: two configurations against a behavioural model
module tb_multi_lane_sdp_ram;
    localparam int LW    = 10;
    localparam int NL    = 2;
    localparam int AW    = 4;
    localparam int W     = LW * NL;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_a, rst_b;
    logic [W-1:0]  wdata;
    logic [AW-1:0] waddr, raddr;
    logic [NL-1:0] we;
    logic          re;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    multi_lane_sdp_ram_if #(.LANE_WIDTH(LW), .NUM_LANES(NL), .ADDR_WIDTH(AW)) if_a ();
    multi_lane_sdp_ram_if #(.LANE_WIDTH(LW), .NUM_LANES(NL), .ADDR_WIDTH(AW)) if_b ();

    assign if_a.wdata = wdata;  assign if_b.wdata = wdata;
    assign if_a.waddr = waddr;  assign if_b.waddr = waddr;
    assign if_a.we    = we;     assign if_b.we    = we;
    assign if_a.raddr = raddr;  assign if_b.raddr = raddr;
    assign if_a.re    = re;     assign if_b.re    = re;

    // a: latency 1, read-first, no clear.  b: latency 2, write-first, clear on reset.
    multi_lane_sdp_ram #(
        .LANE_WIDTH(LW), .NUM_LANES(NL), .ADDR_WIDTH(AW), .OUTPUT_REG("FALSE"),
        .RDW_MODE("READ_FIRST"), .CLEAR_ON_RESET("FALSE"), .RAM_INIT_FILE("")
    ) u_a (.clk_i(clk), .rst_i(rst_a), .bus(if_a));

    multi_lane_sdp_ram #(
        .LANE_WIDTH(LW), .NUM_LANES(NL), .ADDR_WIDTH(AW), .OUTPUT_REG("TRUE"),
        .RDW_MODE("WRITE_FIRST"), .CLEAR_ON_RESET("TRUE"), .RAM_INIT_FILE("")
    ) u_b (.clk_i(clk), .rst_i(rst_b), .bus(if_b));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Model: per-config word array, remaining clear count, results scheduled by arrival cycle.
    logic [W-1:0] mem_m [2][DEPTH];
    int           clear_left [2];
    logic         sv [2][4];
    logic [W-1:0] sd [2][4];
    logic [W-1:0] exp_rdata [2];
    logic         exp_rvalid [2];
    logic         exp_busy [2];
    int           cyc = 0;
    bit           model_on = 0;

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < DEPTH; i++) mem_m[d][i] = '0;
            for (int s = 0; s < 4; s++) begin sv[d][s] = 1'b0; sd[d][s] = '0; end
            clear_left[d] = 0;
            exp_rdata[d] = '0; exp_rvalid[d] = 1'b0; exp_busy[d] = 1'b0;
        end
    end

    always @(posedge clk) begin
        logic [W-1:0] rd, tmp;
        logic         r;
        for (int d = 0; d < 2; d++) begin
            r = (d == 0) ? rst_a : rst_b;
            if (r) begin
                clear_left[d] = (d == 1) ? DEPTH : 0;
                for (int s = 0; s < 4; s++) sv[d][s] = 1'b0;
                exp_rdata[d] = '0;
            end else if (clear_left[d] > 0) begin
                mem_m[d][DEPTH - clear_left[d]] = '0;
                clear_left[d] = clear_left[d] - 1;
            end else begin
                if (re) begin
                    rd = mem_m[d][raddr];
                    if (d == 1 && raddr == waddr)
                        for (int k = 0; k < NL; k++)
                            if (we[k]) rd[k*LW +: LW] = wdata[k*LW +: LW];
                    sv[d][(cyc + d) % 4] = 1'b1;
                    sd[d][(cyc + d) % 4] = rd;
                end
                tmp = mem_m[d][waddr];
                for (int k = 0; k < NL; k++)
                    if (we[k]) tmp[k*LW +: LW] = wdata[k*LW +: LW];
                mem_m[d][waddr] = tmp;
            end
            exp_rvalid[d] = sv[d][cyc % 4];
            if (sv[d][cyc % 4]) exp_rdata[d] = sd[d][cyc % 4];
            sv[d][cyc % 4] = 1'b0;
            exp_busy[d] = (clear_left[d] > 0);
        end
        cyc++;
        model_on = 1;
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("a_rdata",  if_a.rdata,  exp_rdata[0]);
            check("a_rvalid", if_a.rvalid, exp_rvalid[0]);
            check("a_busy",   if_a.busy,   exp_busy[0]);
            check("b_rdata",  if_b.rdata,  exp_rdata[1]);
            check("b_rvalid", if_b.rvalid, exp_rvalid[1]);
            check("b_busy",   if_b.busy,   exp_busy[1]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] dat, input logic [NL-1:0] m);
        waddr = a; wdata = dat; we = m;
        tick();
        we = '0;
    endtask

    task automatic rd_issue(input logic [AW-1:0] a);
        raddr = a; re = 1'b1;
        tick();
        re = 1'b0;
    endtask

    function automatic logic [W-1:0] data_of(input int i);
        logic [9:0] hi, lo;
        hi = 10'h100 + 10'(i);
        lo = 10'h3FF - 10'(i);
        return {hi, lo};
    endfunction

    task automatic wait_clear(output int cnt);
        cnt = 0;
        while (if_b.busy && cnt < 40) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        int cnt;
        rst_a = 1'b1; rst_b = 1'b1;
        we = '0; re = 1'b0; wdata = '0; waddr = '0; raddr = '0;
        tick(); tick();
        check("reset_a_rvalid", if_a.rvalid, 0);
        check("reset_b_busy", if_b.busy, 1);
        rst_a = 1'b0; rst_b = 1'b0;

        // Traffic during the initial clear: a accepts it, b must ignore it.
        wr(4'd9, {10'h123, 10'h321}, 2'b11);
        rd_issue(4'd9);
        check("a_busy_read", if_a.rdata, {10'h123, 10'h321});
        wait_clear(cnt);
        check("b_initial_clear_len", cnt + 2, 16);

        // Lane enables and latency.
        wr(4'd3, {10'h155, 10'h0AA}, 2'b11);
        wr(4'd3, {10'h000, 10'h3FF}, 2'b01);
        rd_issue(4'd3);
        check("lat_a_rvalid", if_a.rvalid, 1);
        check("lat_a_rdata", if_a.rdata, {10'h155, 10'h3FF});
        check("lat_b_early_rvalid", if_b.rvalid, 0);
        tick();
        check("lat_b_rvalid", if_b.rvalid, 1);
        check("lat_b_rdata", if_b.rdata, {10'h155, 10'h3FF});
        check("lat_a_hold_rvalid", if_a.rvalid, 0);
        check("lat_a_hold_rdata", if_a.rdata, {10'h155, 10'h3FF});
        tick();
        check("lat_b_hold_rvalid", if_b.rvalid, 0);

        // Read-during-write collision.
        wr(4'd5, {10'h001, 10'h002}, 2'b11);
        waddr = 4'd5; wdata = {10'h0AB, 10'h0CD}; we = 2'b10;
        raddr = 4'd5; re = 1'b1;
        tick();
        we = '0; re = 1'b0;
        check("rdw_read_first", if_a.rdata, {10'h001, 10'h002});
        tick();
        check("rdw_write_first", if_b.rdata, {10'h0AB, 10'h002});
        rd_issue(4'd5);
        tick();

        // Back-to-back wrap: 16 writes, then 16 reads with re held.
        for (int i = 0; i < DEPTH; i++) begin
            waddr = AW'(i); wdata = data_of(i); we = 2'b11;
            tick();
        end
        we = '0;
        re = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            raddr = AW'(i);
            tick();
        end
        re = 1'b0;
        tick(); tick();
        rd_issue(4'd0);
        check("wrap_a_addr0", if_a.rdata, {10'h100, 10'h3FF});
        tick();
        check("wrap_b_addr0", if_b.rdata, {10'h100, 10'h3FF});
        rd_issue(4'd15);
        check("wrap_a_addr15", if_a.rdata, {10'h10F, 10'h3F0});
        tick();
        check("wrap_b_addr15", if_b.rdata, {10'h10F, 10'h3F0});

        // Full clear with user traffic held active throughout.
        for (int i = 0; i < DEPTH; i++) wr(AW'(i), {10'h3FF, 10'h3FF}, 2'b11);
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        waddr = 4'd2; wdata = {10'h2AA, 10'h155}; we = 2'b11;
        raddr = 4'd6; re = 1'b1;
        wait_clear(cnt);
        we = '0; re = 1'b0;
        check("clear_len", cnt, 16);
        for (int i = 0; i < DEPTH; i++) rd_issue(AW'(i));
        tick();
        rd_issue(4'd2);
        tick();
        check("clear_b_addr2_rvalid", if_b.rvalid, 1);
        check("clear_b_addr2", if_b.rdata, 0);

        // Reset reasserted at clear cycle 7.
        for (int i = 0; i < DEPTH; i++) wr(AW'(i), {10'h3FF, 10'h3FF}, 2'b11);
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        wait_clear(cnt);
        check("restart_clear_len", cnt, 16);
        rd_issue(4'd15);
        tick();
        check("restart_b_addr15", if_b.rdata, 0);
        check("restart_b_rvalid", if_b.rvalid, 1);

        // Reset without clear keeps contents.
        check("pre_rst_a_rdata", if_a.rdata, {10'h3FF, 10'h3FF});
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        check("rst_a_rdata", if_a.rdata, 0);
        check("rst_a_rvalid", if_a.rvalid, 0);
        rd_issue(4'd3);
        check("rst_a_kept", if_a.rdata, {10'h3FF, 10'h3FF});
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
